// File: rtl/counter_timer_ctrl.sv
// Sequencer for a 74x163-style 4-bit counter: one-shot or periodic timing with abort.
// Define TIMER_PERIOD_CNT_EN to build the saturating PERIODS counter; otherwise PERIODS reads 8'h00.
module counter_timer_ctrl (
   input  logic       CLK,
   input  logic       RST_L,
   input  logic       START,
   input  logic       STOP,
   input  logic       MODE,
   input  logic [3:0] PRESET,
   input  logic       RCO,
   output logic       CLR_L,
   output logic       LD_L,
   output logic       ENP,
   output logic       ENT,
   output logic [3:0] D,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] PERIODS
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIN, S_ABORT} state_t;

   state_t     state, state_nxt;
   logic       mode_q;
   logic [3:0] preset_q;
   logic       accept;
   logic       rco_hit;

   assign accept  = (state == S_IDLE) && START && !STOP;
   assign rco_hit = (state == S_RUN) && RCO && !STOP;
   assign D       = preset_q;

   // Outputs decode from the asynchronously reset state, so RST_L drops ENP/ENT without a clock.
   always_ff @(posedge CLK or negedge RST_L) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!RST_L) begin
         state    <= S_IDLE;
         mode_q   <= 1'b0;
         preset_q <= 4'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            mode_q   <= MODE;
            preset_q <= PRESET;
         end
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_nxt = state;
      CLR_L     = 1'b1;
      LD_L      = 1'b1;
      ENP       = 1'b0;
      ENT       = 1'b0;
      BUSY      = 1'b1;
      DONE      = 1'b0;
      case (state)
         S_IDLE: begin
            BUSY = 1'b0;
            if (accept) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            LD_L      = 1'b0;
            state_nxt = STOP ? S_ABORT : S_RUN;
         end
         S_RUN: begin
            ENP = 1'b1;
            ENT = 1'b1;
            if (STOP) begin
               state_nxt = S_ABORT;
            end else if (RCO) begin
               // Periodic mode reloads instead of letting the counter wrap through zero.
               if (mode_q) LD_L = 1'b0;
               else        state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            CLR_L     = 1'b0;
            DONE      = 1'b1;
            state_nxt = S_IDLE;
         end
         S_ABORT: begin
            CLR_L     = 1'b0;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef TIMER_PERIOD_CNT_EN
   logic [7:0] periods_q;

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         periods_q <= 8'd0;
      end else if (accept) begin
         periods_q <= 8'd0;
      end else if (rco_hit && (periods_q != 8'hFF)) begin
         periods_q <= periods_q + 8'd1;
      end
   end

   assign PERIODS = periods_q;
`else
   logic unused_rco_hit;

   assign unused_rco_hit = rco_hit;
   assign PERIODS        = 8'h00;
`endif

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Bench for counter_timer_ctrl driving a 74x163-style counter; directed scenarios then random stimulus
// compared every cycle against a transaction-level model of the timer.
module tb_counter_timer_ctrl;

   logic       CLK = 1'b0;
   logic       RST_L, START, STOP, MODE, RCO;
   logic [3:0] PRESET;
   logic       CLR_L, LD_L, ENP, ENT, BUSY, DONE;
   logic [3:0] D;
   logic [7:0] PERIODS;
   logic [3:0] q = 4'd0;

   int n_cmp = 0;
   int n_err = 0;

   counter_timer_ctrl dut (
      .CLK(CLK), .RST_L(RST_L), .START(START), .STOP(STOP), .MODE(MODE),
      .PRESET(PRESET), .RCO(RCO), .CLR_L(CLR_L), .LD_L(LD_L), .ENP(ENP),
      .ENT(ENT), .D(D), .BUSY(BUSY), .DONE(DONE), .PERIODS(PERIODS)
   );

   always #5 CLK = ~CLK;

   // 74x163: synchronous clear beats load beats count; RCO gated by ENT. Not touched by RST_L.
   assign RCO = (q == 4'hF) && ENT;
   always @(posedge CLK) begin
      if (!CLR_L)          q <= 4'd0;
      else if (!LD_L)      q <= D;
      else if (ENP && ENT) q <= q + 4'd1;
   end

   // Reference model: what the timer is doing right now, plus the counter value it should produce.
   bit         m_loading, m_running, m_done, m_abort;
   bit         m_mode;
   logic [3:0] m_preset;
   logic [3:0] m_q = 4'd0;
   int         m_periods;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_loading = 0; m_running = 0; m_done = 0; m_abort = 0;
      m_mode = 0; m_preset = 4'd0; m_periods = 0;
   endtask

   task automatic compare();
      logic exp_clr, exp_ld, exp_en, exp_done, exp_busy;
      int   exp_periods;
      exp_clr  = 1'b1;
      exp_ld   = 1'b1;
      exp_en   = 1'b0;
      exp_done = 1'b0;
      exp_busy = m_loading | m_running | m_done | m_abort;
      if (m_loading) exp_ld = 1'b0;
      if (m_running) begin
         exp_en = 1'b1;
         if (m_mode && (m_q == 4'hF) && !STOP) exp_ld = 1'b0;
      end
      if (m_done) begin
         exp_clr  = 1'b0;
         exp_done = 1'b1;
      end
      if (m_abort) exp_clr = 1'b0;
`ifdef TIMER_PERIOD_CNT_EN
      exp_periods = m_periods;
`else
      exp_periods = 0;
`endif
      check("clr_l",   32'(CLR_L),   32'(exp_clr));
      check("ld_l",    32'(LD_L),    32'(exp_ld));
      check("enp",     32'(ENP),     32'(exp_en));
      check("ent",     32'(ENT),     32'(exp_en));
      check("done",    32'(DONE),    32'(exp_done));
      check("busy",    32'(BUSY),    32'(exp_busy));
      check("d",       32'(D),       32'(m_preset));
      check("periods", 32'(PERIODS), 32'(exp_periods));
      check("q",       32'(q),       32'(m_q));
   endtask

   // Advance the model across one rising edge given the inputs applied during that cycle.
   task automatic model_advance(input bit st, input bit sp, input bit md, input logic [3:0] pr);
      if (m_done || m_abort) begin
         m_done  = 0;
         m_abort = 0;
         m_q     = 4'd0;
      end else if (m_loading) begin
         m_loading = 0;
         m_q       = m_preset;
         if (sp) m_abort   = 1;
         else    m_running = 1;
      end else if (m_running) begin
         if (sp) begin
            m_running = 0;
            m_abort   = 1;
            m_q       = m_q + 4'd1;
         end else if (m_q == 4'hF) begin
            if (m_periods < 255) m_periods++;
            if (m_mode) begin
               m_q = m_preset;
            end else begin
               m_running = 0;
               m_done    = 1;
               m_q       = 4'd0;
            end
         end else begin
            m_q = m_q + 4'd1;
         end
      end else if (st && !sp) begin
         m_loading = 1;
         m_mode    = md;
         m_preset  = pr;
         m_periods = 0;
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input bit st, input bit sp, input bit md, input logic [3:0] pr);
      START = st; STOP = sp; MODE = md; PRESET = pr;
      #1;
      compare();
      @(posedge CLK);
      model_advance(st, sp, md, pr);
      @(negedge CLK);
   endtask

   // 10 ns reset pulse spanning one rising edge; the counter must hold its value throughout.
   task automatic pulse_reset();
      START = 0; STOP = 0;
      RST_L = 1'b0;
      model_reset();
      #1;
      compare();
      @(negedge CLK);
      compare();
      RST_L = 1'b1;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0);
   endtask

   initial begin
      RST_L = 1'b0; START = 0; STOP = 0; MODE = 0; PRESET = 4'd0;
      model_reset();
      #3;
      compare();
      @(negedge CLK);
      RST_L = 1'b1;

      // One-shot, preset 10: six RUN cycles then DONE.
      step(1, 0, 0, 4'b1010);
      idle_steps(10);

      // Periodic, preset 12: three periods, then STOP.
      step(1, 0, 1, 4'b1100);
      idle_steps(13);
      step(0, 1, 0, 4'd0);
      idle_steps(3);

      // Periodic, STOP at Q=13.
      step(1, 0, 1, 4'b1100);
      idle_steps(2);
      step(0, 1, 0, 4'd0);
      idle_steps(3);

      // STOP coincident with RCO; START and a foreign preset during RUN are ignored.
      step(1, 0, 1, 4'b1100);
      step(0, 0, 0, 4'd0);
      step(1, 0, 0, 4'd3);
      step(0, 0, 0, 4'd0);
      step(0, 0, 0, 4'd0);
      step(0, 1, 0, 4'd0);
      idle_steps(3);

      // START and STOP together in IDLE stays idle; STOP during LOAD aborts.
      step(1, 1, 1, 4'd5);
      step(1, 0, 1, 4'd5);
      step(0, 1, 0, 4'd0);
      idle_steps(3);

      // Preset 15 in both modes; periodic run long enough to saturate PERIODS.
      step(1, 0, 0, 4'hF);
      idle_steps(4);
      step(1, 0, 1, 4'hF);
      idle_steps(270);
      step(0, 1, 0, 4'd0);
      idle_steps(2);

      // Reset in the middle of a run.
      step(1, 0, 1, 4'd6);
      idle_steps(5);
      pulse_reset();
      idle_steps(2);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            pulse_reset();
         end else begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
